// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter draining four fall-through FIFOs into one output FIFO.
// Each granted queue may be popped up to weight[q] times before the grant rotates.
// A weight of zero removes the queue from arbitration entirely.
module arbiter_wrr #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  pausa,
    input  logic [3:0]            empty,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_idx,
    input  logic [WEIGHT_W-1:0]   cfg_weight,
    output logic [3:0]            pop,
    output logic                  push,
    output logic [DATA_W-1:0]     data_out,
    output logic [1:0]            grant,
    output logic                  active
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_grant;
    logic [1:0]          w_grant_nxt;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          w_rr_ptr_nxt;
    logic [WEIGHT_W-1:0] r_credit;
    logic [WEIGHT_W-1:0] w_credit_nxt;
    logic [WEIGHT_W-1:0] r_weight [4];
    logic                r_push;
    logic [DATA_W-1:0]   r_data_out;

    logic [3:0]          w_elig;
    logic                w_sel_vld;
    logic [1:0]          w_sel;
    logic [1:0]          w_cand;
    logic                w_pop_any;
    logic                w_switch;

    // A queue can be granted only if it has a word and a non-zero weight.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = !empty[i] && (r_weight[i] != '0);
        end
    end

    // Round-robin pick: first eligible queue starting at r_rr_ptr; scanning
    // backwards lets the nearest candidate overwrite farther ones.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = r_rr_ptr;
        w_cand    = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_rr_ptr + 2'(k);
            if (w_elig[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel     = w_cand;
            end
        end
    end

    // Pop strobe: only in SERVE, unstalled, with data and remaining credit.
    always_comb begin
        w_pop_any = (r_state == S_SERVE) && enb && !pausa &&
                    !empty[r_grant] && (r_credit != '0);
        pop       = w_pop_any ? (4'b0001 << r_grant) : 4'b0000;
    end

    // Next-state logic: load on grant, decrement per pop, rotate on switch.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_credit_nxt = r_credit;
        w_switch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enb && w_sel_vld) begin
                    w_state_nxt  = S_SERVE;
                    w_grant_nxt  = w_sel;
                    w_credit_nxt = r_weight[w_sel];
                    w_rr_ptr_nxt = w_sel + 2'd1;
                end
            end
            S_SERVE: begin
                // Stalled or disabled: everything holds, grant is never preempted.
                if (enb && !pausa) begin
                    if (w_pop_any) begin
                        w_credit_nxt = r_credit - WEIGHT_W'(1);
                    end
                    w_switch = (w_pop_any && (r_credit == WEIGHT_W'(1))) ||
                               (empty[r_grant] && !w_pop_any);
                    if (w_switch) begin
                        if (w_sel_vld) begin
                            w_grant_nxt  = w_sel;
                            w_credit_nxt = r_weight[w_sel];
                            w_rr_ptr_nxt = w_sel + 2'd1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    // Weight table: writable at any time; loads read the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_weight[i] <= WEIGHT_W'(1);
            end
        end else if (cfg_we) begin
            r_weight[cfg_idx] <= cfg_weight;
        end
    end

    // Output FIFO write port: one cycle behind the pop, data held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_push <= w_pop_any;
            if (w_pop_any) begin
                r_data_out <= data_in[r_grant*DATA_W +: DATA_W];
            end
        end
    end

    assign push     = r_push;
    assign data_out = r_data_out;
    assign grant    = r_grant;
    assign active   = (r_state == S_SERVE);

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: models four fall-through FIFOs around the
// arbiter and checks pop order, push latency/data, stalls and reset.
module tb_arbiter_wrr;

    localparam int DW = 8;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enb = 1'b1;
    logic            pausa = 1'b0;
    logic [3:0]      empty = 4'hF;
    logic [4*DW-1:0] data_in = '0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_idx = 2'd0;
    logic [WW-1:0]   cfg_weight = '0;
    logic [3:0]      pop;
    logic            push;
    logic [DW-1:0]   data_out;
    logic [1:0]      grant;
    logic            active;

    arbiter_wrr #(.DATA_W(DW), .WEIGHT_W(WW)) dut (
        .clk(clk), .rst(rst), .enb(enb), .pausa(pausa), .empty(empty),
        .data_in(data_in), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_weight(cfg_weight), .pop(pop), .push(push), .data_out(data_out),
        .grant(grant), .active(active)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int cnt[4];
    int popped[4];
    int pop_log[$];

    logic [3:0]    s_pop;
    logic          s_push;
    logic [DW-1:0] s_dout;
    logic [1:0]    s_grant;
    logic          s_active;
    logic          prev_pop = 1'b0;
    logic [DW-1:0] prev_word = '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FIFO model outputs: empty flag and head word (queue id in the high nibble).
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            empty[i] = (cnt[i] == 0);
            data_in[i*DW +: DW] = DW'(i*16 + popped[i]);
        end
    endtask

    // One clock: sample at negedge, check push/data latency, then advance FIFOs.
    task automatic step();
        int idx;
        idx = 0;
        @(negedge clk);
        s_pop = pop; s_push = push; s_dout = data_out; s_grant = grant; s_active = active;
        chk_eq("push_lat", s_push, prev_pop);
        if (prev_pop) chk_eq("dout", s_dout, prev_word);
        chk_eq("pop_onehot", ($countones(s_pop) <= 1), 1);
        prev_pop = |s_pop;
        for (int i = 0; i < 4; i++) if (s_pop[i]) idx = i;
        if (|s_pop) begin
            prev_word = DW'(idx*16 + popped[idx]);
            pop_log.push_back(idx);
        end
        @(posedge clk);
        #1;
        if (|s_pop) begin
            cnt[idx]--;
            popped[idx]++;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1; pausa = 1'b0; enb = 1'b1; cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; popped[i] = 0; end
        pop_log.delete();
        prev_pop = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_wr(input int idx, input int w);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_weight = WW'(w);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic chk_log(input string tag, input int exp_q[$]);
        chk_eq({tag, "_len"}, pop_log.size(), exp_q.size());
        foreach (exp_q[j])
            chk_eq(tag, (j < pop_log.size()) ? pop_log[j] : 32'hFFFF_FFFF, exp_q[j]);
    endtask

    initial begin
        int q[$];
        logic any_act;

        // Asynchronous reset state before any clock edge.
        #2;
        chk_eq("rst_pop", pop, 0);
        chk_eq("rst_push", push, 0);
        chk_eq("rst_dout", data_out, 0);
        chk_eq("rst_grant", grant, 0);
        chk_eq("rst_active", active, 0);

        // Default weights, queues 0 and 2 with 3 words: strict alternation.
        do_reset();
        cnt[0] = 3; cnt[2] = 3; drive();
        repeat (12) step();
        q = {0, 2, 0, 2, 0, 2};
        chk_log("alt02", q);
        chk_eq("alt02_idle", s_active, 0);

        // weight[1]=3, weight[3]=1, deep queues: 1,1,1,3 with no bubbles.
        do_reset();
        cfg_wr(1, 3); cfg_wr(3, 1);
        cnt[1] = 100; cnt[3] = 100; drive();
        repeat (16) step();
        q = {1, 1, 1, 3, 1, 1, 1, 3, 1, 1, 1, 3, 1, 1, 1};
        chk_log("wrr13", q);

        // weight[2]=0 with only queue 2 holding data: never served.
        do_reset();
        cfg_wr(2, 0);
        cnt[2] = 5; drive();
        any_act = 1'b0;
        repeat (10) begin step(); any_act |= s_active; end
        chk_eq("w0_pops", pop_log.size(), 0);
        chk_eq("w0_active", any_act, 0);

        // Queue 0, weight 4: two pops, pause 5 cycles, disable 2, then 2 more.
        do_reset();
        cfg_wr(0, 4);
        cnt[0] = 4; drive();
        step(); chk_eq("pz_c0_active", s_active, 0);
        step(); chk_eq("pz_c1_pop", s_pop, 4'b0001);
        step(); chk_eq("pz_c2_pop", s_pop, 4'b0001);
        pausa = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_eq("pz_hold_pop", s_pop, 0);
            chk_eq("pz_hold_grant", s_grant, 0);
            chk_eq("pz_hold_active", s_active, 1);
        end
        pausa = 1'b0; enb = 1'b0;
        repeat (2) begin step(); chk_eq("enb_hold_pop", s_pop, 0); end
        enb = 1'b1;
        step(); chk_eq("pz_r1_pop", s_pop, 4'b0001);
        step(); chk_eq("pz_r2_pop", s_pop, 4'b0001);
        chk_eq("pz_r2_grant", s_grant, 0);
        repeat (4) step();
        chk_eq("pz_total", pop_log.size(), 4);

        // Queue 3 weight 4 with 2 words: switch on empty, rr_ptr wraps to 0.
        do_reset();
        cfg_wr(3, 4);
        cnt[3] = 2; drive();
        step();
        step(); chk_eq("e3_c1_pop", s_pop, 4'b1000);
        step(); chk_eq("e3_c2_pop", s_pop, 4'b1000);
        cnt[0] = 1; cnt[2] = 1; drive();
        step();
        chk_eq("e3_c3_pop", s_pop, 0);
        chk_eq("e3_c3_grant", s_grant, 3);
        chk_eq("e3_c3_active", s_active, 1);
        step(); chk_eq("e3_c4_pop", s_pop, 4'b0001); chk_eq("e3_c4_grant", s_grant, 0);
        step(); chk_eq("e3_c5_pop", s_pop, 4'b0100); chk_eq("e3_c5_grant", s_grant, 2);
        repeat (3) step();
        q = {3, 3, 0, 2};
        chk_log("e3seq", q);
        chk_eq("e3_idle", s_active, 0);

        // Weight write on the same edge as the load of that queue: old weight used.
        do_reset();
        cnt[0] = 10; cnt[2] = 10;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_weight = WW'(3);
        drive();
        step();
        cfg_we = 1'b0;
        repeat (6) step();
        q = {0, 2, 0, 0, 0, 2};
        chk_log("wload", q);

        // Reset between edges mid-SERVE; weights return to 1 afterwards.
        do_reset();
        cfg_wr(1, 5);
        cnt[1] = 10; cnt[3] = 10; drive();
        step(); step(); step();
        chk_eq("mr_pre_active", s_active, 1);
        #2 rst = 1'b1;
        prev_pop = 1'b0;
        #1;
        chk_eq("mr_pop", pop, 0);
        chk_eq("mr_push", push, 0);
        chk_eq("mr_dout", data_out, 0);
        chk_eq("mr_grant", grant, 0);
        chk_eq("mr_active", active, 0);
        step();
        rst = 1'b0;
        step(); chk_eq("mr_r0_pop", s_pop, 0); chk_eq("mr_r0_active", s_active, 0);
        step(); chk_eq("mr_r1_pop", s_pop, 4'b0010);
        step(); chk_eq("mr_r2_pop", s_pop, 4'b1000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
